uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8-bit UART transmitter that drives the serial line read by uart_receiver.
- Bytes are written into an internal FIFO and serialized as 8N1 frames, LSB first, at a rate chosen by baud_set.
- Lets a host queue a burst of bytes without waiting on each frame.
- Sits between a byte-producing core (command responder, loopback logic) and the Rs232_Tx pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used to compute the baud dividers.
- DEPTH, 16, FIFO depth in bytes; must be a power of two, 2 to 256.
- AW, 4, FIFO address width; equals log2(DEPTH).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous active-high reset.
- baud_set  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=9600.
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  8  byte to queue.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  AW+1  number of bytes currently in the FIFO.
- overflow  out  1  one-cycle pulse when a write is dropped.
- Rs232_Tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is in flight.
- Tx_Done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: Rs232_Tx=1, busy=0, Tx_Done=0, overflow=0, level=0, empty=1, full=0. FIFO pointers cleared.
- Reset asserted mid-frame aborts the frame and drops all queued bytes. Rs232_Tx returns high on the next edge.
- Baud divider DIV = CLK_FREQ/baud, integer truncation. At 50 MHz: 5208, 2604, 1302, 868, 434.
- baud_set is sampled only at frame start. A change mid-frame affects the next frame only.
- Write: wr_en=1 with full=0 stores wr_data; level increments on the next edge.
- Write while full: byte is discarded, overflow pulses one cycle. full is evaluated before any same-cycle pop.
- Write and pop in the same cycle: level is unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START when empty=0. The byte is popped in that same cycle, so Rs232_Tx goes low on the following edge.
- Latency: a write at edge N into an empty FIFO gives empty=0 after N, pop at N+1, and the start bit on Rs232_Tx from N+2.
- START: Rs232_Tx=0 for DIV clocks, then → DATA.
- DATA: bit index 0..7, each held for DIV clocks, LSB first; after bit 7 → STOP.
- STOP: Rs232_Tx=1 for DIV clocks, then → IDLE.
- Tx_Done pulses for the single cycle on which the FSM enters IDLE.
- busy is high from the first start-bit cycle through the last stop-bit cycle.
- Back-to-back frames: exactly one IDLE cycle (line high) between a stop bit and the next start bit. Frame period is 10*DIV+1 clocks.
- Bit counter and divider counter reset to 0 at every state transition; the divider wraps at DIV-1.
- level saturates logically at DIV-independent bounds 0..DEPTH. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV clocks. Frame becomes 11 bits; period 11*DIV+1.
- Undefined: no PARITY state, 8N1 framing as above.
- The receiver side must be built with the matching setting.

Test Plan:
- Reset, baud_set=4, write 8'hAA once → Rs232_Tx low 2 clocks after write. Line reads 0,0,1,0,1,0,1,0,1,1, each for 434 clocks. Tx_Done at 4341 clocks after start; uart_receiver outputs data_byte=8'hAA with Rx_Done.
- Write 8'h55, 8'hAA, 8'h0F on consecutive cycles → three frames separated by exactly one high cycle. Tx_Done pulses 3 times. Receiver gets 55, AA, 0F in order.
- Hold transmission busy, write 17 bytes with DEPTH=16 → first byte popped, so full asserts after 17 accepted writes are in flight. An 18th write pulses overflow and level stays 16.
- Assert Rst for 1 cycle during bit 3 of a frame → Rs232_Tx=1 next edge. level=0, busy=0, no Tx_Done pulse, no receiver Rx_Done.
- Change baud_set from 4 to 0 during frame 1 of 2 → frame 1 bits 434 clocks wide, frame 2 bits 5208 clocks wide.
- With UART_TX_PARITY_EN, send 8'h07 → parity bit 1, frame 11 bits long. Send 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle for uart_tx_fifo: byte strobe from the producer and FIFO status back to it.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;

  modport master (output wr_en, wr_data, input full, empty, level, overflow);
  modport slave  (input wr_en, wr_data, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer (LSB first, selectable baud).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [2:0]    baud_set,
  uart_tx_fifo_if.slave wr,
  output logic          Rs232_Tx,
  output logic          busy,
  output logic          Tx_Done
);

  localparam int DIV_MAX = CLK_FREQ / 9600;
  localparam int DW      = $clog2(DIV_MAX + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic [DW-1:0] div_of(input logic [2:0] sel);
    int d;
    case (sel)
      3'd1:    d = CLK_FREQ / 19200;
      3'd2:    d = CLK_FREQ / 38400;
      3'd3:    d = CLK_FREQ / 57600;
      3'd4:    d = CLK_FREQ / 115200;
      default: d = CLK_FREQ / 9600;
    endcase
    return DW'(d);
  endfunction

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, overflow_q;

  state_t        state, state_nx;
  logic [DW-1:0] cnt, div_q;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          tick, tx_bit, done_nx;
  logic          tx_q, busy_q, done_q;

  // A write is refused whenever the FIFO is full at the start of the cycle, even if a pop happens too.
  assign push = wr.wr_en && !wr.full;
  assign pop  = (state == IDLE) && !wr.empty;

  assign wr.full     = (count == (AW+1)'(DEPTH));
  assign wr.empty    = (count == '0);
  assign wr.level    = count;
  assign wr.overflow = overflow_q;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wr.wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr.wr_en && wr.full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte and divider are latched at frame start, so a baud_set change only affects later frames.
  always_ff @(posedge Clk) begin
    if (pop) begin
      shift_q <= mem[rd_ptr];
      div_q   <= div_of(baud_set);
    end
  end

  assign tick = (cnt == div_q - 1'b1);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!wr.empty) state_nx = START;
      START: if (tick) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && bit_idx == 3'd7) state_nx = PARITY;
      PARITY: if (tick) state_nx = STOP;
`else
      DATA:   if (tick && bit_idx == 3'd7) state_nx = STOP;
`endif
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state_nx != state || state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      cnt     <= '0;
      bit_idx <= bit_idx + 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  always_comb begin
    tx_bit  = 1'b1;
    done_nx = 1'b0;
    case (state)
      START:  tx_bit = 1'b0;
      DATA:   tx_bit = shift_q[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_bit = even_parity(shift_q);
`endif
      STOP:   done_nx = tick;
      default: tx_bit = 1'b1;
    endcase
  end

  // Line and busy are registered, so they trail the state register by one clock.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_bit;
      busy_q <= (state != IDLE);
      done_q <= done_nx;
    end
  end

  assign Rs232_Tx = tx_q;
  assign busy     = busy_q;
  assign Tx_Done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected frames, a line monitor decodes and compares.
module tb_uart_tx_fifo;

  // 1 MHz clock keeps frames short: dividers are 104 (9600), 26 (38400), 8 (115200).
  localparam int CLK_FREQ = 1000000;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int DIV0     = 104;
  localparam int DIV2     = 26;
  localparam int DIV4     = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         abort;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] baud_set = 3'd4;
  logic       Rs232_Tx, busy, Tx_Done;

  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   starts[$];

  uart_tx_fifo_if #(.AW(AW)) wr_if ();

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .baud_set(baud_set),
    .wr      (wr_if),
    .Rs232_Tx(Rs232_Tx),
    .busy    (busy),
    .Tx_Done (Tx_Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) if (Tx_Done === 1'b1) done_seen <= done_seen + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input int div, input bit abort);
    exp_t e;
    e.data  = b;
    e.div   = div;
    e.abort = abort;
    exp_q.push_back(e);
    if (!abort) done_exp++;
  endtask

  task automatic put(input logic [7:0] b);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_data = b;
    @(posedge Clk); #1;
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0 && wr_if.empty == 1'b1) && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n < budget), 1);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  // Line monitor: decodes every frame and compares it against the oldest expected entry.
  initial begin : monitor
    exp_t        e;
    logic [10:0] ebits;
    logic [7:0]  data_obs;
    bit          bits_ok, busy_ok, aborted;
    int          done_pos, done_cnt, bi;
    forever begin
      @(negedge Clk);
      if (Rst == 1'b0 && Rs232_Tx === 1'b0) begin
        starts.push_back(cyc);
        chk("unexpected_frame", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin e.data = 8'h00; e.div = DIV4; e.abort = 1'b0; end
        ebits = '1;
        ebits[0] = 1'b0;
        for (int i = 0; i < 8; i++) ebits[i+1] = e.data[i];
`ifdef UART_TX_PARITY_EN
        ebits[9] = ^e.data;
`endif
        bits_ok = 1; busy_ok = 1; aborted = 0;
        done_pos = -1; done_cnt = 0; data_obs = '0;
        for (int c = 0; c < NBITS * e.div && !aborted; c++) begin
          if (c != 0) @(negedge Clk);
          if (Rst === 1'b1) aborted = 1;
          else begin
            bi = c / e.div;
            if (Rs232_Tx !== ebits[bi]) bits_ok = 0;
            if (busy !== 1'b1) busy_ok = 0;
            if (bi >= 1 && bi <= 8 && (c % e.div) == e.div / 2) data_obs[bi-1] = Rs232_Tx;
            if (Tx_Done === 1'b1) begin done_pos = c; done_cnt++; end
          end
        end
        chk("frame_abort", int'(aborted), int'(e.abort));
        if (!aborted) begin
          chk("frame_data", int'(data_obs), int'(e.data));
          chk("frame_bits", int'(bits_ok), 1);
          chk("frame_busy", int'(busy_ok), 1);
          chk("tx_done_pos", (done_cnt == 1) ? done_pos : -1, NBITS * e.div - 1);
          @(negedge Clk);
          chk("idle_gap", int'({Rs232_Tx, busy}), 2);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    wr_if.wr_en   = 1'b0;
    wr_if.wr_data = 8'h00;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_line",  int'(Rs232_Tx), 1);
    chk("rst_ctrl",  int'({busy, Tx_Done, wr_if.overflow}), 0);
    chk("rst_level", int'(wr_if.level), 0);
    chk("rst_flags", int'({wr_if.empty, wr_if.full}), 2);
    Rst = 1'b0;
    @(posedge Clk); #1;

    // Single byte at 115200: pop one clock after the write, start bit the clock after that.
    baud_set = 3'd4;
    push_exp(8'hAA, DIV4, 0);
    put(8'hAA);
    chk("lat_level_after_write", int'(wr_if.level), 1);
    chk("lat_empty_after_write", int'(wr_if.empty), 0);
    chk("lat_line_n", int'(Rs232_Tx), 1);
    @(posedge Clk); #1;
    chk("lat_level_after_pop", int'(wr_if.level), 0);
    chk("lat_line_n1", int'(Rs232_Tx), 1);
    @(posedge Clk); #1;
    chk("lat_line_n2", int'({Rs232_Tx, busy}), 1);
    wait_idle(400);

    // Three back-to-back frames: one idle clock between them, period 10*DIV+1 (11*DIV+1 with parity).
    starts.delete();
    push_exp(8'h55, DIV4, 0);
    push_exp(8'hAA, DIV4, 0);
    push_exp(8'h0F, DIV4, 0);
    put(8'h55);
    put(8'hAA);
    put(8'h0F);
    wait_idle(600);
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_period_1", starts[1] - starts[0], NBITS * DIV4 + 1);
      chk("b2b_period_2", starts[2] - starts[1], NBITS * DIV4 + 1);
    end

    // Fill while the first frame is on the line: 17 accepted writes, 18th overflows.
    for (int i = 0; i < 17; i++) begin
      push_exp(8'h10 + 8'(i), DIV4, 0);
      put(8'h10 + 8'(i));
    end
    chk("fill_level", int'(wr_if.level), 16);
    chk("fill_full", int'(wr_if.full), 1);
    put(8'hEE);
    chk("ovf_pulse", int'(wr_if.overflow), 1);
    chk("ovf_level", int'(wr_if.level), 16);
    @(posedge Clk); #1;
    chk("ovf_clear", int'(wr_if.overflow), 0);
    wait_idle(17 * (NBITS * DIV4 + 1) + 200);

    // Reset during data bit 3 aborts the frame and drops the second queued byte.
    baud_set = 3'd2;
    push_exp(8'hC3, DIV2, 1);
    put(8'hC3);
    put(8'h5A);
    repeat (1 + 4 * DIV2 + 10) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("abort_line", int'(Rs232_Tx), 1);
    chk("abort_level", int'(wr_if.level), 0);
    chk("abort_ctrl", int'({busy, Tx_Done}), 0);
    chk("abort_empty", int'(wr_if.empty), 1);
    starts.delete();
    repeat (300) @(posedge Clk);
    #1;
    chk("abort_no_frame", starts.size(), 0);
    wait_idle(50);

    // baud_set changes mid-frame: first frame keeps 115200, second uses 9600.
    baud_set = 3'd4;
    push_exp(8'h3C, DIV4, 0);
    push_exp(8'h96, DIV0, 0);
    put(8'h3C);
    put(8'h96);
    repeat (5) @(posedge Clk);
    #1;
    baud_set = 3'd0;
    wait_idle(NBITS * (DIV4 + DIV0) + 400);

    // Parity boundary bytes: 0x07 has odd weight, 0x03 even.
    baud_set = 3'd4;
    push_exp(8'h07, DIV4, 0);
    put(8'h07);
    wait_idle(400);
    push_exp(8'h03, DIV4, 0);
    put(8'h03);
    wait_idle(400);

    chk("tx_done_count", done_seen, done_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
